// File: rtl/mux2_rr_arbiter_if.sv
// Bundle of the two-requester arbiter bus: request side (req/d/last),
// grant side (gnt/sel) and the single downstream valid/ready port.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             last0;
  logic             last1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;

  // Environment side: requesters plus the downstream consumer.
  modport master (
    output req0, req1, d0, d1, last0, last1, y_ready,
    input  gnt0, gnt1, sel, y, y_valid
  );

  // Arbiter side: owns the grants, the mux select and the muxed output.
  modport slave (
    input  req0, req1, d0, d1, last0, last1, y_ready,
    output gnt0, gnt1, sel, y, y_valid
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 data mux.
// One requester owns the bus per burst; ownership is released on a last
// beat, on reaching MAX_BURST beats, or when the owner drops its request.
// On release the other requester is served first if it is waiting, so a
// contended bus hands off back to back with no idle cycle.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input logic              clk,
  input logic              rst,
  mux2_rr_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // Beat count value on which the current beat is the final permitted one.
  localparam logic [7:0] CNT_LIMIT = 8'(MAX_BURST - 1);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       prio_reg;
  logic       prio_next;
  logic [7:0] cnt_reg;
  logic [7:0] cnt_next;
  logic       sel_reg;
  logic       sel_next;
  logic [1:0] gnt_reg;
  logic [1:0] gnt_next;

  // Per-requester views, index 0 = requester 0, index 1 = requester 1.
  logic [1:0] req_vec;
  logic [1:0] last_vec;
  logic [1:0] beat_vec;
  logic [1:0] rel_vec;

  logic       at_limit;
  logic       beat;
  logic       release_now;
  logic       owner;
  logic       other;
  logic       idle_winner;

  assign req_vec  = {bus.req1, bus.req0};
  assign last_vec = {bus.last1, bus.last0};
  assign at_limit = (cnt_reg == CNT_LIMIT);

  // Per-requester beat and release detection; only the owner can produce either.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign beat_vec[gi] = gnt_reg[gi] & req_vec[gi] & bus.y_ready;
      assign rel_vec[gi]  = gnt_reg[gi] &
                            (~req_vec[gi] | (beat_vec[gi] & (last_vec[gi] | at_limit)));
    end
  endgenerate

  assign beat        = |beat_vec;
  assign release_now = |rel_vec;
  assign owner       = (state_reg == ST_OWN1);
  assign other       = ~owner;
  // From idle a lone requester wins outright; a tie goes to the priority pointer.
  assign idle_winner = (req_vec == 2'b11) ? prio_reg : req_vec[1];

  // Next-state logic: grant from idle, count beats, release and hand off.
  always_comb begin
    state_next = state_reg;
    prio_next  = prio_reg;
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req_vec) begin
          state_next = idle_winner ? ST_OWN1 : ST_OWN0;
          sel_next   = idle_winner;
          cnt_next   = 8'd0;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (release_now) begin
          prio_next = other;
          cnt_next  = 8'd0;
          if (req_vec[other]) begin
            state_next = other ? ST_OWN1 : ST_OWN0;
            sel_next   = other;
          end else if (req_vec[owner]) begin
            // Nobody else waiting: the same requester starts a fresh burst.
            state_next = owner ? ST_OWN1 : ST_OWN0;
            sel_next   = owner;
          end else begin
            // sel keeps pointing at the previous owner while idle.
            state_next = ST_IDLE;
          end
        end else if (beat) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Grants are decoded from the next state so they come straight out of flops.
  always_comb begin
    gnt_next    = 2'b00;
    gnt_next[0] = (state_next == ST_OWN0);
    gnt_next[1] = (state_next == ST_OWN1);
  end

  // State registers; reset overrides everything, including a burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      prio_reg  <= 1'b0;
      cnt_reg   <= 8'd0;
      sel_reg   <= 1'b0;
      gnt_reg   <= 2'b00;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      gnt_reg   <= gnt_next;
    end
  end

  assign bus.gnt0    = gnt_reg[0];
  assign bus.gnt1    = gnt_reg[1];
  assign bus.sel     = sel_reg;
  assign bus.y       = sel_reg ? bus.d1 : bus.d0;
  assign bus.y_valid = |(gnt_reg & req_vec);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter (WIDTH=8, MAX_BURST=4).
// Each vector describes one clock cycle: the inputs driven and the grant,
// select and valid expected during that cycle. Expected beats are pushed
// to a scoreboard when driven and popped by a monitor when the DUT hands
// the beat downstream.
module tb_mux2_rr_arbiter;

  typedef struct {
    bit       rst;
    bit       req0;
    bit       req1;
    bit       last0;
    bit       last1;
    bit       rdy;
    bit [7:0] d0;
    bit [7:0] d1;
    bit       e_g0;
    bit       e_g1;
    bit       e_sel;
    bit       e_v;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   step_no;
  bit [7:0] exp_q[$];
  vec_t tbl[$];

  mux2_rr_arbiter_if #(.WIDTH(8)) bus ();

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit r0, bit r1, bit l0, bit l1, bit rdy,
                              bit [7:0] a, bit [7:0] b,
                              bit g0, bit g1, bit s, bit v);
    vec_t t;
    t.rst = r;   t.req0 = r0; t.req1 = r1; t.last0 = l0; t.last1 = l1;
    t.rdy = rdy; t.d0 = a;    t.d1 = b;
    t.e_g0 = g0; t.e_g1 = g1; t.e_sel = s; t.e_v = v;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, required %0h", name, idx, act, req);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then check the outputs.
  task automatic step(vec_t v);
    bit [7:0] exp_y;
    @(negedge clk);
    step_no++;
    rst         = v.rst;
    bus.req0    = v.req0;
    bus.req1    = v.req1;
    bus.last0   = v.last0;
    bus.last1   = v.last1;
    bus.y_ready = v.rdy;
    bus.d0      = v.d0;
    bus.d1      = v.d1;
    exp_y = v.e_sel ? v.d1 : v.d0;
    if (v.e_v && v.rdy) exp_q.push_back(exp_y);
    #1;
    chk("gnt0", step_no, 32'(bus.gnt0), 32'(v.e_g0));
    chk("gnt1", step_no, 32'(bus.gnt1), 32'(v.e_g1));
    chk("sel", step_no, 32'(bus.sel), 32'(v.e_sel));
    chk("y_valid", step_no, 32'(bus.y_valid), 32'(v.e_v));
    chk("y", step_no, 32'(bus.y), 32'(exp_y));
    $display("step %0d rst=%0b req=%0b%0b last=%0b%0b rdy=%0b gnt=%0b%0b sel=%0b y=%02h y_valid=%0b",
             step_no, v.rst, v.req1, v.req0, v.last1, v.last0, v.rdy,
             bus.gnt1, bus.gnt0, bus.sel, bus.y, bus.y_valid);
  endtask

  // Monitor: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin
    #2;
    if (bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", step_no, 32'(bus.y), 32'hFFFF_FFFF);
      end else begin
        chk("beat_data", step_no, 32'(bus.y), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    step_no     = 0;
    rst         = 1'b1;
    bus.req0    = 1'b0;
    bus.req1    = 1'b0;
    bus.last0   = 1'b0;
    bus.last1   = 1'b0;
    bus.y_ready = 1'b0;
    bus.d0      = 8'h00;
    bus.d1      = 8'h00;

    //                 rst r0 r1 l0 l1 rdy d0     d1      g0 g1 s v
    // Reset state.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00,  0, 0, 0, 0));
    // Single requester, last on beat 4 coincides with forced release.
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'hA5, 8'h3C,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'hA5, 8'h3C,  1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'hA5, 8'h3C,  1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'hA5, 8'h3C,  1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 8'hA5, 8'h3C,  1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'hA5, 8'h3C,  1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'hA5, 8'h3C,  0, 0, 0, 0));
    // Contention from reset, 2-beat bursts, back-to-back handoffs.
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h11, 8'h22,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 8'h11, 8'h22,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 8'h11, 8'h22,  1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 8'h12, 8'h22,  1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 8'h13, 8'h23,  0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 8'h13, 8'h24,  0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 8'h15, 8'h25,  1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 8'h16, 8'h25,  1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h17, 8'h27,  0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h18, 8'h28,  0, 0, 1, 0));
    // Abandon: owner 0 drops without last, requester 1 takes over.
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'h31, 8'h41,  0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'h32, 8'h41,  1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 8'h33, 8'h42,  1, 0, 0, 0));
    // Backpressure: 5 stalled cycles with last1 held, then the beat.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 8'h34, 8'h5A,  0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 8'h34, 8'h5A,  0, 1, 1, 1));
    // Forced release after 4 beats with requester 1 waiting.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 1, 0, 0, 1, 8'(8'h61 + i), 8'h70,  1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'h65, 8'h71,  0, 1, 1, 0));
    // Forced release with nobody waiting: re-grant restarts the beat count.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'(8'h81 + i), 8'h90,  1, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 1, 0, 0, 1, 8'(8'h85 + i), 8'h91,  1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 8'h89, 8'h92,  0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h8A, 8'h93,  0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h8B, 8'h94,  0, 0, 1, 0));

    foreach (tbl[i]) step(tbl[i]);

    // Reset in the middle of an OWN1 burst (cnt=3), then re-grant.
    step(mk(0, 0, 1, 0, 0, 1, 8'hC0, 8'hD0,  0, 0, 1, 0));
    step(mk(0, 0, 1, 0, 0, 1, 8'hC0, 8'hD1,  0, 1, 1, 1));
    step(mk(0, 0, 1, 0, 0, 1, 8'hC0, 8'hD2,  0, 1, 1, 1));
    step(mk(0, 0, 1, 0, 0, 1, 8'hC0, 8'hD3,  0, 1, 1, 1));
    step(mk(1, 0, 1, 0, 0, 0, 8'hC0, 8'hD4,  0, 1, 1, 1));
    step(mk(0, 0, 1, 0, 0, 0, 8'hC0, 8'hD4,  0, 0, 0, 0));
    step(mk(0, 0, 1, 0, 1, 1, 8'hC0, 8'hD5,  0, 1, 1, 1));
    step(mk(0, 0, 0, 0, 0, 1, 8'hC0, 8'hD6,  0, 1, 1, 0));
    step(mk(0, 0, 0, 0, 0, 1, 8'hC0, 8'hD7,  0, 0, 1, 0));

    @(negedge clk);
    #3;
    chk("scoreboard_empty", step_no, 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
